// File: rtl/adc_spi_out.sv
// SPI master sending five 16-bit control words as one 80-bit, chip-select framed burst.
// Mode 0 style: SCK idles low, MOSI changes on the falling edge, MSB of Data0 first.
module adc_spi_out #(
  parameter int CLK_DIV = 12
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Start,
  input  logic [15:0] i_Data0,
  input  logic [15:0] i_Data1,
  input  logic [15:0] i_Data2,
  input  logic [15:0] i_Data3,
  input  logic [15:0] i_Data4,
  output logic        o_SPI_CS,
  output logic        o_SPI_Clock,
  output logic        o_SPI_Data,
  output logic        o_Busy,
  output logic        o_Done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_HOLD,
    S_GAP
  } state_t;

  localparam logic [7:0] PH_LAST  = 8'(CLK_DIV - 1);
  localparam logic [6:0] BIT_LAST = 7'd79;

  state_t      state_q;
  logic [7:0]  phase_q;
  logic [6:0]  bit_q;
  logic [79:0] shift_q;
  logic        cs_q;
  logic        sck_q;
  logic        busy_q;
  logic        done_q;
  logic        phase_end;

  assign phase_end = (phase_q == PH_LAST);

  // MOSI is the top bit of the shift register itself, so it stays a registered output.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      cs_q    <= 1'b1;
      sck_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          phase_q <= '0;
          if (i_Start) begin
            shift_q <= {i_Data0, i_Data1, i_Data2, i_Data3, i_Data4};
            bit_q   <= '0;
            cs_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_LOW;
          end
        end
        S_LOW: begin
          if (phase_end) begin
            phase_q <= '0;
            sck_q   <= 1'b1;
            state_q <= S_HIGH;
          end else begin
            phase_q <= phase_q + 8'd1;
          end
        end
        S_HIGH: begin
          if (phase_end) begin
            phase_q <= '0;
            sck_q   <= 1'b0;
            if (bit_q == BIT_LAST) begin
              shift_q <= '0;
              state_q <= S_HOLD;
            end else begin
              bit_q   <= bit_q + 7'd1;
              shift_q <= {shift_q[78:0], 1'b0};
              state_q <= S_LOW;
            end
          end else begin
            phase_q <= phase_q + 8'd1;
          end
        end
        S_HOLD: begin
          if (phase_end) begin
            phase_q <= '0;
            cs_q    <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_GAP;
          end else begin
            phase_q <= phase_q + 8'd1;
          end
        end
        S_GAP: begin
          if (phase_end) begin
            phase_q <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            phase_q <= phase_q + 8'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_SPI_CS    = cs_q;
  assign o_SPI_Clock = sck_q;
  assign o_SPI_Data  = shift_q[79];
  assign o_Busy      = busy_q;
  assign o_Done      = done_q;

endmodule

// File: tb/tb_adc_spi_out.sv
// Bench for adc_spi_out: two instances (CLK_DIV=12 and CLK_DIV=1), a stimulus process
// queueing expected frames and a single monitor that decodes the SPI lines and compares.
`timescale 1ns/1ps
module tb_adc_spi_out;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  start;
  logic [15:0] d [2][5];

  logic cs_a, sck_a, mosi_a, busy_a, done_a;
  logic cs_b, sck_b, mosi_b, busy_b, done_b;
  wire [1:0] cs   = {cs_b, cs_a};
  wire [1:0] sck  = {sck_b, sck_a};
  wire [1:0] mosi = {mosi_b, mosi_a};
  wire [1:0] busy = {busy_b, busy_a};
  wire [1:0] done = {done_b, done_a};

  adc_spi_out #(.CLK_DIV(12)) u_a (
    .i_Clock(clk), .i_Reset(rst), .i_Start(start[0]),
    .i_Data0(d[0][0]), .i_Data1(d[0][1]), .i_Data2(d[0][2]), .i_Data3(d[0][3]), .i_Data4(d[0][4]),
    .o_SPI_CS(cs_a), .o_SPI_Clock(sck_a), .o_SPI_Data(mosi_a), .o_Busy(busy_a), .o_Done(done_a)
  );

  adc_spi_out #(.CLK_DIV(1)) u_b (
    .i_Clock(clk), .i_Reset(rst), .i_Start(start[1]),
    .i_Data0(d[1][0]), .i_Data1(d[1][1]), .i_Data2(d[1][2]), .i_Data3(d[1][3]), .i_Data4(d[1][4]),
    .o_SPI_CS(cs_b), .o_SPI_Clock(sck_b), .o_SPI_Data(mosi_b), .o_Busy(busy_b), .o_Done(done_b)
  );

  typedef struct {
    logic [79:0] data;
    bit          full;
    int          gap;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   exp_done[2];
  bit   mon_en   = 1'b0;
  bit   idle_chk = 1'b0;
  bit   end_chk  = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  logic [1:0]  p_cs = 2'b11, p_sck = 2'b00, p_mosi = 2'b00, p_busy = 2'b00;
  logic [79:0] sh [2];
  int          nbits[2], cs_len[2], gap_len[2], busy_len[2], n_done[2];
  bit          last_full[2];
  bit          p_rst = 1'b0;
  bit          end_done = 1'b0;

  task automatic mon(input int i);
    int   cd;
    exp_t e;
    bit   have;
    cd = (i == 0) ? 12 : 1;
    if (p_cs[i] && !cs[i]) begin
      have = (i == 0) ? (qa.size() > 0) : (qb.size() > 0);
      chk("frame_expected", 64'(have), 64'd1);
      if (have) begin
        if (i == 0) e = qa[0]; else e = qb[0];
        if (e.gap >= 0) chk("cs_high_gap", 64'(gap_len[i]), 64'(e.gap));
      end
      cs_len[i] = 0;
      nbits[i]  = 0;
      sh[i]     = '0;
    end
    if (!p_cs[i] && cs[i]) begin
      have = (i == 0) ? (qa.size() > 0) : (qb.size() > 0);
      if (have) begin
        if (i == 0) e = qa.pop_front(); else e = qb.pop_front();
        if (e.full) begin
          for (int k = 0; k < 5; k++)
            chk("rx_word", 64'(sh[i][79-16*k -: 16]), 64'(e.data[79-16*k -: 16]));
          chk("sck_rises", 64'(nbits[i]), 64'd80);
          chk("cs_low_len", 64'(cs_len[i]), 64'(161 * cd));
          chk("done_at_cs_rise", 64'(done[i]), 64'd1);
        end else begin
          chk("partial_bits_lt80", 64'(nbits[i] < 80), 64'd1);
          chk("no_done_on_abort", 64'(done[i]), 64'd0);
        end
        last_full[i] = e.full;
      end
      gap_len[i] = 0;
    end
    if (!cs[i] && !p_sck[i] && sck[i]) begin
      chk("mosi_stable", 64'(mosi[i]), 64'(p_mosi[i]));
      sh[i] = {sh[i][78:0], mosi[i]};
      nbits[i]++;
    end
    if (!p_busy[i] && busy[i]) busy_len[i] = 0;
    if (p_busy[i] && !busy[i] && last_full[i])
      chk("busy_len", 64'(busy_len[i]), 64'(162 * cd));
    if (cs[i]) gap_len[i]++; else cs_len[i]++;
    if (busy[i]) busy_len[i]++;
    if (done[i]) n_done[i]++;
  endtask

  always @(negedge clk) begin
    if (p_rst)
      chk("reset_outputs", 64'({cs, sck, mosi, busy, done}), 64'(10'b11_00_00_00_00));
    if (mon_en) begin
      for (int i = 0; i < 2; i++) mon(i);
      if (idle_chk)
        chk("idle_outputs", 64'({cs, sck, mosi, busy, done}), 64'(10'b11_00_00_00_00));
    end
    if (end_chk && !end_done) begin
      chk("frames_left_a", 64'(qa.size()), 64'd0);
      chk("frames_left_b", 64'(qb.size()), 64'd0);
      chk("done_pulses_a", 64'(n_done[0]), 64'(exp_done[0]));
      chk("done_pulses_b", 64'(n_done[1]), 64'(exp_done[1]));
      end_done = 1'b1;
    end
    p_rst  = rst;
    p_cs   = cs;
    p_sck  = sck;
    p_mosi = mosi;
    p_busy = busy;
  end

  // ---------------- stimulus ----------------
  task automatic set_data(input int i, input logic [79:0] w);
    for (int k = 0; k < 5; k++) d[i][k] = w[79-16*k -: 16];
  endtask

  task automatic expect_frame(input int i, input logic [79:0] w, input bit full, input int gap);
    exp_t e;
    e.data = w;
    e.full = full;
    e.gap  = gap;
    if (i == 0) qa.push_back(e); else qb.push_back(e);
    if (full) exp_done[i]++;
  endtask

  task automatic pulse_start(input int i);
    @(posedge clk); #1 start[i] = 1'b1;
    @(posedge clk); #1 start[i] = 1'b0;
  endtask

  task automatic send(input int i, input logic [79:0] w, input bit full, input int gap);
    set_data(i, w);
    expect_frame(i, w, full, gap);
    pulse_start(i);
  endtask

  localparam logic [79:0] W1 = {16'h005A, 16'h010E, 16'h01FF, 16'h1234, 16'h00A5};
  localparam logic [79:0] W2 = {16'hC3C3, 16'h8001, 16'h7FFE, 16'h0F0F, 16'hABCD};
  localparam logic [79:0] WH = {16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
  localparam logic [79:0] W3 = {16'hAAAA, 16'h5555, 16'hAAAA, 16'h5555, 16'hAAAA};
  localparam logic [79:0] W4 = {16'hBEEF, 16'hCAFE, 16'h0123, 16'h4567, 16'h89AB};

  initial begin
    rst   = 1'b1;
    start = 2'b00;
    set_data(0, '0);
    set_data(1, '0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1 mon_en = 1'b1; idle_chk = 1'b1;
    repeat (100) @(posedge clk);
    #1 idle_chk = 1'b0;

    send(0, W1, 1'b1, -1);
    repeat (2000) @(posedge clk);

    send(1, {5{16'hFFFF}}, 1'b1, -1);
    repeat (200) @(posedge clk);
    send(1, {5{16'h0000}}, 1'b1, -1);
    repeat (200) @(posedge clk);

    // Second start mid-frame and a Data0 change must not disturb the frame in flight.
    send(0, W2, 1'b1, -1);
    repeat (499) @(posedge clk);
    pulse_start(0);
    repeat (100) @(posedge clk);
    #1 d[0][0] = 16'hDEAD;
    repeat (1500) @(posedge clk);

    // Start held high: two back-to-back frames separated by CLK_DIV+1 cycles of CS high.
    set_data(0, WH);
    expect_frame(0, WH, 1'b1, -1);
    expect_frame(0, WH, 1'b1, 13);
    @(posedge clk); #1 start[0] = 1'b1;
    repeat (1950) @(posedge clk);
    #1 start[0] = 1'b0;
    repeat (2000) @(posedge clk);

    // Reset mid-frame abandons the frame; the next start yields a clean full frame.
    send(0, W3, 1'b0, -1);
    repeat (700) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    send(0, W4, 1'b1, -1);
    repeat (2000) @(posedge clk);

    #1 end_chk = 1'b1;
    @(negedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
